// File: rtl/bounce_gen_if.sv
// Command handshake and generated-signal bundle for bounce_gen.
// Handshake: a request transfers on a rising clock edge where cmd_valid and
// cmd_ready are both 1. cmd_level and cmd_bounces are captured only on that
// edge. cmd_valid seen while cmd_ready is 0 is ignored and nothing is queued.
interface bounce_gen_if;
  logic       cmd_valid;
  logic       cmd_level;
  logic [3:0] cmd_bounces;
  logic       cmd_ready;
  logic       sig_out;
  logic       busy;
  logic       done;

  // Requester side: drives commands and observes the generated signal.
  modport master (
    output cmd_valid,
    output cmd_level,
    output cmd_bounces,
    input  cmd_ready,
    input  sig_out,
    input  busy,
    input  done
  );

  // Generator side.
  modport slave (
    input  cmd_valid,
    input  cmd_level,
    input  cmd_bounces,
    output cmd_ready,
    output sig_out,
    output busy,
    output done
  );
endinterface

// File: rtl/bounce_gen.sv
// Bouncy-edge generator: on each accepted request it drives sig_out with
// pseudo-random bounce values for cmd_bounces cycles, then holds the target
// level for SETTLE cycles and pulses done on the first idle cycle.
module bounce_gen #(
  parameter logic [7:0] SEED   = 8'hA5,
  parameter int         SETTLE = 4
) (
  input  logic           clock,
  input  logic           reset,
  bounce_gen_if.slave    bif,
  output logic [1:0]     dbg_state,
  output logic [7:0]     dbg_lfsr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE);

  state_t     state, state_nxt;
  logic [7:0] lfsr, lfsr_nxt;
  logic [3:0] bounce_cnt, bounce_cnt_nxt;
  logic [7:0] settle_cnt, settle_cnt_nxt;
  logic       level, level_nxt;
  logic       sig_q, sig_nxt;
  logic       done_q, done_nxt;

  // Register all state; reset abandons any request without a done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lfsr       <= SEED;
      bounce_cnt <= 4'd0;
      settle_cnt <= 8'd0;
      level      <= 1'b0;
      sig_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      bounce_cnt <= bounce_cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      level      <= level_nxt;
      sig_q      <= sig_nxt;
      done_q     <= done_nxt;
    end
  end

  // Next-state and datapath: LFSR only steps in BOUNCE, sig_out holds in IDLE.
  always_comb begin
    state_nxt      = state;
    lfsr_nxt       = lfsr;
    bounce_cnt_nxt = bounce_cnt;
    settle_cnt_nxt = settle_cnt;
    level_nxt      = level;
    sig_nxt        = sig_q;
    done_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bif.cmd_valid) begin
          level_nxt = bif.cmd_level;
          if (bif.cmd_bounces != 4'd0) begin
            state_nxt      = ST_BOUNCE;
            bounce_cnt_nxt = bif.cmd_bounces;
          end else begin
            state_nxt      = ST_SETTLE;
            settle_cnt_nxt = SETTLE_LOAD;
          end
        end
      end
      ST_BOUNCE: begin
        // Bounce value uses the LFSR before this edge's advance.
        sig_nxt        = level ^ lfsr[0];
        lfsr_nxt       = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        bounce_cnt_nxt = bounce_cnt - 4'd1;
        if (bounce_cnt == 4'd1) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        sig_nxt        = level;
        settle_cnt_nxt = settle_cnt - 8'd1;
        if (settle_cnt == 8'd1) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake and status decode straight from the state register.
  always_comb begin
    bif.cmd_ready = (state == ST_IDLE);
    bif.busy      = (state != ST_IDLE);
    bif.sig_out   = sig_q;
    bif.done      = done_q;
    dbg_state     = state;
    dbg_lfsr      = lfsr;
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: the driver pushes the expected
// {sig_out, done} sequence for every accepted request; a monitor pops one
// entry per cycle that follows a busy cycle.
module tb_bounce_gen;

  localparam int SETTLE = 4;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;

  bounce_gen_if bif ();

  bounce_gen #(.SEED(8'hA5), .SETTLE(SETTLE)) dut (
    .clock     (clock),
    .reset     (reset),
    .bif       (bif),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         checks_n = 0;
  int         errors_n = 0;
  logic [1:0] exp_q[$];
  logic [7:0] m_lfsr = 8'hA5;
  logic       prev_busy = 1'b0;
  logic [3:0] fsh = 4'd0;
  logic       filt = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
    checks_n++;
    if (got !== req) begin
      errors_n++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Expected output for one request, from the LFSR recurrence.
  task automatic push_req(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({lvl ^ m_lfsr[0], 1'b0});
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    for (int j = 0; j < SETTLE; j++)
      exp_q.push_back({lvl, (j == SETTLE - 1)});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bif.cmd_ready && t < 100) begin
      tick();
      t++;
    end
    if (!bif.cmd_ready) begin
      checks_n++;
      errors_n++;
      $display("FAIL ready_timeout: cmd_ready still %0b after %0d cycles, required 1", bif.cmd_ready, t);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bif.done && t < 100) begin
      tick();
      t++;
    end
    checks_n++;
    if (!bif.done) begin
      errors_n++;
      $display("FAIL done_timeout: done still %0b after %0d cycles, required 1", bif.done, t);
    end
  endtask

  // Driver: present one request, hold until accepted, then drop cmd_valid.
  task automatic issue(input logic lvl, input int n);
    bif.cmd_valid   = 1'b1;
    bif.cmd_level   = lvl;
    bif.cmd_bounces = 4'(n);
    wait_ready();
    push_req(lvl, n);
    tick();
    bif.cmd_valid   = 1'b0;
  endtask

  // cmd_valid held high; level alternates and is scrambled while busy.
  task automatic run_held(input int count);
    logic lvl;
    bif.cmd_valid = 1'b1;
    for (int k = 0; k < count; k++) begin
      lvl             = (k % 2 == 0);
      bif.cmd_level   = lvl;
      bif.cmd_bounces = 4'(k + 1);
      wait_ready();
      if (k > 0) chk("b2b_accept_in_done", {7'd0, bif.done}, 8'h01);
      push_req(lvl, k + 1);
      tick();
      bif.cmd_level   = ~lvl;
      bif.cmd_bounces = 4'd9;
    end
    bif.cmd_valid = 1'b0;
    wait_done();
  endtask

  // Scoreboard monitor: one output entry per cycle after a busy cycle.
  always @(negedge clock) begin
    logic [1:0] e;
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy) begin
        checks_n++;
        if (exp_q.size() == 0) begin
          errors_n++;
          $display("FAIL sb_underflow: got sig_out=%0b done=%0b, required a queued entry", bif.sig_out, bif.done);
        end else begin
          e = exp_q.pop_front();
          if ({bif.sig_out, bif.done} !== e) begin
            errors_n++;
            $display("FAIL sb_out: got sig_out=%0b done=%0b, required sig_out=%0b done=%0b",
                     bif.sig_out, bif.done, e[1], e[0]);
          end
        end
      end else if (bif.done) begin
        checks_n++;
        errors_n++;
        $display("FAIL spurious_done: got done=1 with no request in flight, required 0");
      end
      prev_busy = bif.busy;
    end
  end

  // Team 4-stage glitch filter fed by sig_out.
  always @(posedge clock) begin
    fsh <= {fsh[2:0], bif.sig_out};
    if (&fsh)       filt <= 1'b1;
    else if (~|fsh) filt <= 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b0;
    bif.cmd_valid   = 1'b0;
    bif.cmd_level   = 1'b0;
    bif.cmd_bounces = 4'd0;
    repeat (3) tick();
    chk("rst_sig_out", {7'd0, bif.sig_out}, 8'h00);
    chk("rst_done", {7'd0, bif.done}, 8'h00);
    chk("rst_ready", {7'd0, bif.cmd_ready}, 8'h01);
    chk("rst_busy", {7'd0, bif.busy}, 8'h00);
    chk("rst_state", {6'd0, dbg_state}, 8'h00);
    chk("rst_lfsr", dbg_lfsr, 8'hA5);
    reset = 1'b1;
    tick();

    // level=1 N=3: bounce 0,1,0 from A5,4A,95 then 1 x4; LFSR ends at 2A.
    issue(1'b1, 3);
    chk("busy_after_accept", {7'd0, bif.busy}, 8'h01);
    wait_done();
    chk("lfsr_after_n3", dbg_lfsr, 8'h2A);

    // level=0 N=2 from 2A: lfsr[0] of 2A and 54 are both 0, so 0,0 then 0 x4.
    // 2A -> 54 -> A9 under the feedback taps 7,5,4,3.
    issue(1'b0, 2);
    wait_done();
    chk("lfsr_after_n2", dbg_lfsr, 8'hA9);

    // N=0: straight to settle, LFSR untouched.
    issue(1'b1, 0);
    wait_done();
    chk("lfsr_after_n0", dbg_lfsr, 8'hA9);
    tick();
    chk("done_one_cycle", {7'd0, bif.done}, 8'h00);
    chk("idle_hold_sig", {7'd0, bif.sig_out}, 8'h01);

    // Back-to-back with cmd_valid held high.
    run_held(4);
    chk("lfsr_after_held", dbg_lfsr, m_lfsr);

    // Reset in the middle of a bounce phase.
    issue(1'b1, 6);
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_lfsr = 8'hA5;
    tick();
    chk("midrst_sig_out", {7'd0, bif.sig_out}, 8'h00);
    chk("midrst_ready", {7'd0, bif.cmd_ready}, 8'h01);
    chk("midrst_done", {7'd0, bif.done}, 8'h00);
    chk("midrst_lfsr", dbg_lfsr, 8'hA5);
    reset = 1'b1;
    tick();
    chk("midrst_no_done", {7'd0, bif.done}, 8'h00);
    issue(1'b1, 3);
    wait_done();
    chk("lfsr_repeat_n3", dbg_lfsr, 8'h2A);

    // Glitch filter must reach the level 4 cycles after done for N=0..15.
    for (int n = 0; n < 16; n++) begin
      logic lvl;
      lvl = (n % 2 == 0);
      issue(lvl, n);
      wait_done();
      repeat (4) tick();
      chk($sformatf("filter_n%0d", n), {7'd0, filt}, {7'd0, lvl});
    end

    repeat (3) tick();
    chk("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
